// File: rtl/sipo_frame_receiver.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits LSB-first, stop bit,
// word presented on Q with valid/ready. Define SIPO_PARITY_EN for an even-parity bit.
module sipo_frame_receiver #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             D,
    input  logic             ready,
    output logic [WIDTH-1:0] Q,
    output logic             valid,
    output logic             frame_err,
    output logic             overrun
`ifdef SIPO_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
`ifdef SIPO_PARITY_EN
        ,
        PARITY
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             load;
`ifdef SIPO_PARITY_EN
    logic             par_q, par_d;
    logic             parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        q_d         = q_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        load        = 1'b0;
`ifdef SIPO_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!D) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = D ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d   = '0;
                    // Right shift with the new bit entering the MSB leaves bit 0 in shift_q[0].
                    shift_d = (shift_q >> 1) | (WIDTH'(D) << (WIDTH - 1));
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef SIPO_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
`ifdef SIPO_PARITY_EN
            PARITY: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d   = '0;
                    par_d   = D;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d = '0;
                    if (D) begin
                        state_d = IDLE;
`ifdef SIPO_PARITY_EN
                        if (^{shift_q, par_q}) begin
                            parity_err_d = 1'b1;
                        end else begin
                            load = 1'b1;
                        end
`else
                        load = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (D) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // A load wins over an accept on the same edge; overrun only if the old word was not taken.
        if (load) begin
            q_d       = shift_q;
            valid_d   = 1'b1;
            overrun_d = valid_q && !ready;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            q_q         <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            q_q         <= q_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef SIPO_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign Q         = q_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef SIPO_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Directed bench for sipo_frame_receiver (WIDTH=8, CLKS_PER_BIT=4); parity cases
// run only when SIPO_PARITY_EN is defined.
module tb_sipo_frame_receiver;

    localparam int WIDTH = 8;
    localparam int CPB   = 4;
`ifdef SIPO_PARITY_EN
    localparam int LAT = CPB / 2 + CPB * (WIDTH + 1) + 1 + CPB;  // 43
`else
    localparam int LAT = CPB / 2 + CPB * (WIDTH + 1) + 1;        // 39
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             D;
    logic             ready;
    logic [WIDTH-1:0] Q;
    logic             valid;
    logic             frame_err;
    logic             overrun;
`ifdef SIPO_PARITY_EN
    logic             parity_err;
    int               pe_cnt = 0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    bit valid_prev = 1'b0;
    int fe0, ov0;

    sipo_frame_receiver #(
        .WIDTH(WIDTH),
        .CLKS_PER_BIT(CPB),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .D(D),
        .ready(ready),
        .Q(Q),
        .valid(valid),
        .frame_err(frame_err),
        .overrun(overrun)
`ifdef SIPO_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid === 1'b1 && !valid_prev) rise_cyc = cyc;
        valid_prev = (valid === 1'b1);
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
`ifdef SIPO_PARITY_EN
        if (parity_err === 1'b1) pe_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drives one whole frame starting at a falling edge; D is left at the stop value.
    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop_bit,
                              input bit ack_on_load);
        D = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int unsigned i = 0; i < 8; i++) begin
            D = data[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef SIPO_PARITY_EN
        D = par;
        repeat (CPB) @(negedge clk);
`else
        if (par === 1'bx) D = 1'b1;
`endif
        D = stop_bit;
        if (ack_on_load) begin
            repeat (CPB / 2) @(negedge clk);
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
            repeat (CPB / 2 - 1) @(negedge clk);
        end else begin
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic accept();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        D = 1'b0;
        ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_q", 32'(Q), 32'h00);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_fe", 32'(frame_err), 32'd0);
        check("rst_ov", 32'(overrun), 32'd0);
        rst = 1'b0;
        D = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_valid", 32'(valid), 32'd0);

        // nominal 0xA5
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        check("a5_q", 32'(Q), 32'hA5);
        check("a5_valid", 32'(valid), 32'd1);
        check("a5_latency", 32'(rise_cyc - start_cyc), 32'(LAT));
        repeat (5) @(negedge clk);
        check("a5_hold_valid", 32'(valid), 32'd1);
        check("a5_hold_q", 32'(Q), 32'hA5);
        accept();
        check("a5_accept_valid", 32'(valid), 32'd0);
        check("a5_no_pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

        // ready without valid
        accept();
        check("ready_idle_valid", 32'(valid), 32'd0);

        // glitch: one low cycle
        D = 1'b0;
        @(negedge clk);
        D = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_valid", 32'(valid), 32'd0);
        check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);

        // framing error while a word is pending, then a held break
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check("5a_q", 32'(Q), 32'h5A);
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
        check("ferr_ov", 32'(ov_cnt - ov0), 32'd0);
        check("ferr_q", 32'(Q), 32'h5A);
        check("ferr_valid", 32'(valid), 32'd1);
        D = 1'b1;
        repeat (3) @(negedge clk);
        accept();
        check("ferr_accept", 32'(valid), 32'd0);

        // overrun
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        check("ov_11_q", 32'(Q), 32'h11);
        check("ov_11_none", 32'(ov_cnt - ov0), 32'd0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        check("ov_22_q", 32'(Q), 32'h22);
        check("ov_22_valid", 32'(valid), 32'd1);
        check("ov_22_pulse", 32'(ov_cnt - ov0), 32'd1);
        accept();

        // load and accept on the same edge
        ov0 = ov_cnt;
        send_frame(8'h33, 1'b0, 1'b1, 1'b0);
        send_frame(8'h44, 1'b0, 1'b1, 1'b1);
        check("simul_q", 32'(Q), 32'h44);
        check("simul_valid", 32'(valid), 32'd1);
        check("simul_ov", 32'(ov_cnt - ov0), 32'd0);

        // reset mid-frame
        fe0 = fe_cnt; ov0 = ov_cnt;
        D = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        D = 1'b1;
        check("midrst_q", 32'(Q), 32'h00);
        check("midrst_valid", 32'(valid), 32'd0);
        repeat (40) @(negedge clk);
        check("midrst_after_valid", 32'(valid), 32'd0);
        check("midrst_pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

`ifdef SIPO_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        check("par_ok_q", 32'(Q), 32'h07);
        check("par_ok_valid", 32'(valid), 32'd1);
        check("par_ok_latency", 32'(rise_cyc - start_cyc), 32'(LAT));
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h0E, 1'b0, 1'b1, 1'b0);
        check("par_bad_pulse", 32'(pe_cnt), 32'd1);
        check("par_bad_q", 32'(Q), 32'h07);
        check("par_bad_valid", 32'(valid), 32'd1);
        check("par_bad_fe_ov", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_frame_receiver.md
Name: sipo_frame_receiver

Overview:
- Serial-to-parallel frame receiver: the read-side counterpart of the team's D flip-flop storage path.
- Watches a single serial line `D` (idle high), detects a start bit, shifts in WIDTH data bits LSB-first and checks the stop bit.
- Presents the captured word on `Q` with a valid/ready handshake.
- Sits between a serial link pin and any parallel consumer in the design.

Parameters:
- WIDTH, 8, data bits per frame (1..32).
- CLKS_PER_BIT, 4, clock cycles per serial bit; even, >= 2.
- CNT_W, 8, width of the bit-timing counter; must hold CLKS_PER_BIT-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- D  input  1  serial data in; idle = 1.
- ready  input  1  consumer accepts `Q` when `valid`&&`ready`.
- Q  output  WIDTH  last received data word.
- valid  output  1  `Q` holds an unconsumed word.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: new word overwrote an unconsumed word.

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `rst`.
- Reset (`rst`=1 at a rising edge):
  - state=IDLE; `Q`=0, `valid`=0, `frame_err`=0, `overrun`=0; shift register, bit counter and timing counter = 0.
  - Reset mid-frame aborts the frame with no pulses.
- Clock numbering: t0 = first edge in IDLE where `D`=0.
- State machine:
  - IDLE: `D`=0 -> START, timing counter cleared.
  - START: waits CLKS_PER_BIT/2 cycles, then samples `D` at t0+CLKS_PER_BIT/2.
    - 0 -> DATA, counters cleared.
    - 1 -> IDLE. Glitch rejected; no output change.
  - DATA: samples `D` every CLKS_PER_BIT cycles. Bit i (i=0..WIDTH-1) is sampled at t0+CLKS_PER_BIT/2+CLKS_PER_BIT*(i+1). Shift is right, new bit into the MSB, so bit 0 ends up at `Q[0]`. After bit WIDTH-1 -> STOP.
  - STOP: samples `D` one bit period after the last data bit.
    - 1 -> load `Q` from the shift register; `valid`=1 on the next edge -> IDLE.
    - 0 -> `frame_err`=1 for one cycle. `Q` and `valid` unchanged -> WAIT_IDLE.
  - WAIT_IDLE: stays until `D`=1 is sampled -> IDLE. This prevents a break condition (line held low) from re-triggering a start.
- Latency: CLKS_PER_BIT=4, WIDTH=8 -> stop sampled at t0+38, `valid` high after the t0+38 edge.
- Handshake:
  - `valid` stays high and `Q` stable until an edge with `valid`&&`ready`; `valid` falls on that edge.
  - `ready` without `valid` has no effect.
- Simultaneous load and accept on the same edge: new word loaded, `valid` stays 1, `overrun`=0.
- Load while `valid`=1 and `ready`=0: `Q` overwritten with the new word, `valid` stays 1, `overrun`=1 for one cycle.
- Frame reception never stalls on `ready`.
- `frame_err` and `overrun` are registered, single-cycle, and never both set in the same cycle.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, sampled one bit period after the last data bit.
  - Even parity: XOR of data bits and parity bit must be 0.
  - Extra output port `parity_err` (1 bit) pulses one cycle when the frame's stop bit is good but parity fails. In that case `Q` and `valid` are not updated, the FSM returns to IDLE, and `frame_err` is not asserted.
  - Stop bit is sampled one bit period later than without the macro.
- Undefined: no PARITY state, no `parity_err` port; timing as above.

Test Plan:
- Reset: assert `rst` for 2 cycles with `D`=0 -> `Q`=0x00, `valid`=0, no pulses; after release with `D`=1, FSM stays IDLE.
- Nominal frame: WIDTH=8, CLKS_PER_BIT=4, send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), `ready`=0 -> `valid` rises after edge t0+38, `Q`=0xA5; assert `ready` one cycle -> `valid`=0 next edge.
- Glitch: `D` low for 1 cycle only -> START resamples 1, returns to IDLE, `valid` never set.
- Framing error: send 0x3C with stop bit 0, then hold `D`=0 for 20 cycles -> `frame_err` one-cycle pulse, `valid`/`Q` unchanged, no new start until `D` returns 1.
- Overrun and back-to-back: send 0x11 then 0x22 with `ready`=0 -> `overrun` pulses at second load, `Q`=0x22; repeat with `ready`=1 on the load edge -> `overrun`=0, `valid`=1.
- SIPO_PARITY_EN: send 0x07 with parity 1 -> `Q`=0x07, `valid`=1; send 0x07 with parity 0 -> `parity_err` pulse, `valid` unchanged.
